uart_nic_scheduler: RTL and testbench

- Sequences access to one UART NIC controller on behalf of N_REQ requesters, for example OS-simulator instances or other byte sources.
- Transmit side: round-robin arbitration onto the NIC's write strobe/data, with a minimum inter-byte gap of one serial frame time, because the NIC exposes no busy flag.
- Receive side: services the NIC's receive interrupt with a one-cycle read strobe, captures the byte, and holds it for a consumer under valid/ready.
- Sits between the requesters and the NIC, replacing direct wiring of write_nic/read_nic.

---
 rtl/uart_nic_scheduler_pkg.sv | 30 +++
 rtl/uart_nic_scheduler_arbiter.sv | 28 ++
 rtl/uart_nic_scheduler.sv | 166 ++++++++++++++++
 tb/tb_uart_nic_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_nic_scheduler_pkg.sv
// Shared types and constants for the UART NIC scheduler: TX/RX state
// encodings, the default frame length and a sizing helper.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_CAP  = 2'd2
  } rx_state_t;

  // 10 bits at 115200 baud on a 50 MHz clock.
  localparam int DEFAULT_FRAME_CYCLES = 4340;

  // Number of bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((32'sd1 <<< bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/uart_nic_scheduler_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer, wrapping modulo N_REQ.
module uart_rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_valid
);

  // Walk the candidates from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx       = PTR_W'((int'(ptr) + k) % N_REQ);
      grant     = req[idx] ? idx : grant;
      any_valid = any_valid | req[idx];
    end
  end

endmodule

// File: rtl/uart_nic_scheduler.sv
// Scheduler in front of a single UART NIC: round-robin transmit arbitration
// with a one-frame gap between bytes, and an independent receive path that
// services the NIC interrupt and holds the byte under valid/ready.
module uart_nic_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         nic_data_in,
  output logic               nic_write,
  output logic               nic_read,
  input  logic [7:0]         nic_data_out,
  input  logic               nic_rx_irq,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               tx_busy,
  output logic [CNT_W-1:0]   tx_count,
  output logic [CNT_W-1:0]   rx_count
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int GAP_W = clog2(FRAME_CYCLES);

  tx_state_t        tx_state_r;
  tx_state_t        tx_next_s;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] winner_r;
  logic [GAP_W-1:0] gap_r;
  logic [7:0]       tx_byte_r;
  logic [CNT_W-1:0] tx_count_r;
  logic [PTR_W-1:0] grant_s;
  logic             any_valid_s;
  logic [7:0]       req_bytes_s [N_REQ];
  logic [N_REQ-1:0] req_ready_s;

  rx_state_t        rx_state_r;
  rx_state_t        rx_next_s;
  logic             rx_hold_off_r;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic [CNT_W-1:0] rx_count_r;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes_s[g] = req_data[8*g +: 8];
  end

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .any_valid (any_valid_s)
  );

  // TX next state: one WRITE cycle per byte, then a full frame of GAP.
  always_comb begin
    tx_next_s = tx_state_r;
    case (tx_state_r)
      IDLE: begin
        if (any_valid_s) tx_next_s = WRITE;
        else             tx_next_s = IDLE;
      end
      WRITE: tx_next_s = GAP;
      GAP: begin
        if (gap_r == '0) tx_next_s = IDLE;
        else             tx_next_s = GAP;
      end
      default: tx_next_s = IDLE;
    endcase
  end

  // TX state, winner/byte latch, pointer advance, gap timer and write count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_r <= IDLE;
      ptr_r      <= '0;
      winner_r   <= '0;
      gap_r      <= '0;
      tx_byte_r  <= 8'h00;
      tx_count_r <= '0;
    end else begin
      tx_state_r <= tx_next_s;
      case (tx_state_r)
        IDLE: begin
          if (any_valid_s) begin
            winner_r  <= grant_s;
            tx_byte_r <= req_bytes_s[grant_s];
          end
        end
        WRITE: begin
          tx_count_r <= tx_count_r + CNT_W'(1);
          ptr_r      <= (int'(winner_r) == N_REQ - 1) ? '0 : winner_r + PTR_W'(1);
          gap_r      <= GAP_W'(FRAME_CYCLES - 1);
        end
        GAP: begin
          if (gap_r != '0) gap_r <= gap_r - GAP_W'(1);
        end
        default: gap_r <= '0;
      endcase
    end
  end

  // Grant pulse goes only to the latched winner, only in the WRITE cycle.
  always_comb begin
    req_ready_s = '0;
    if (tx_state_r == WRITE) req_ready_s = N_REQ'(1) << winner_r;
    else                     req_ready_s = '0;
  end

  // RX next state; the cycle after a capture ignores the irq while the NIC
  // lowers it.
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      R_IDLE: begin
        if (!rx_hold_off_r && nic_rx_irq && !rx_valid_r) rx_next_s = R_READ;
        else                                              rx_next_s = R_IDLE;
      end
      R_READ:  rx_next_s = R_CAP;
      R_CAP:   rx_next_s = R_IDLE;
      default: rx_next_s = R_IDLE;
    endcase
  end

  // RX state, captured byte, valid flag with handshake clear, and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_r    <= R_IDLE;
      rx_hold_off_r <= 1'b0;
      rx_data_r     <= 8'h00;
      rx_valid_r    <= 1'b0;
      rx_count_r    <= '0;
    end else begin
      rx_state_r    <= rx_next_s;
      rx_hold_off_r <= (rx_state_r == R_CAP);
      if (rx_state_r == R_CAP) begin
        rx_data_r  <= nic_data_out;
        rx_valid_r <= 1'b1;
        rx_count_r <= rx_count_r + CNT_W'(1);
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign req_ready   = req_ready_s;
  assign nic_write   = (tx_state_r == WRITE);
  assign nic_data_in = tx_byte_r;
  assign tx_busy     = (tx_state_r == WRITE) || (tx_state_r == GAP);
  assign tx_count    = tx_count_r;
  assign nic_read    = (rx_state_r == R_READ);
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign rx_count    = rx_count_r;

endmodule

// File: tb/tb_uart_nic_scheduler.sv
// Scoreboard bench for uart_nic_scheduler: the driver issues stimulus and
// predicts TX writes / RX bytes from the scheduling rules; a monitor process
// pops and compares whenever the DUT writes, reads or hands over a byte.
module tb_uart_nic_scheduler;

  localparam int N_REQ = 2;
  localparam int FRAME = 8;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         nic_data_in;
  logic               nic_write;
  logic               nic_read;
  logic [7:0]         nic_data_out = 8'h00;
  logic               nic_rx_irq = 1'b0;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready = 1'b0;
  logic               tx_busy;
  logic [CNT_W-1:0]   tx_count;
  logic [CNT_W-1:0]   rx_count;

  uart_nic_scheduler #(.N_REQ(N_REQ), .FRAME_CYCLES(FRAME), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .nic_data_in(nic_data_in), .nic_write(nic_write),
    .nic_read(nic_read), .nic_data_out(nic_data_out), .nic_rx_irq(nic_rx_irq),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    int               idx;
    logic [7:0]       data;
    logic [CNT_W-1:0] cnt;
  } tx_exp_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  tx_exp_t    txq[$];
  logic [7:0] rxq[$];
  logic [7:0] nic_q[$];
  dchk_t      dq[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Requester / reference-model state
  logic [N_REQ-1:0] rv = '0;
  logic [7:0]       rd [N_REQ];
  bit               lock [N_REQ];
  int               drop_cyc [N_REQ];
  bit               hold = 0, tx_en = 0, drop_en = 0, rx_en = 0;
  logic [N_REQ-1:0] tx_mask = '1;
  int               tx_pct = 0, rdy_mode = 0;
  int               m_ptr = 0, m_next = 0, m_wcyc = -100, m_cnt = 0;
  int               rx_total = 0, pop_at = -1;
  bit               hs_prev = 0;

  task automatic dchk(string nm, logic [31:0] act, logic [31:0] exp);
    dchk_t d;
    d.nm = nm; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: consume queued direct checks, then scoreboard DUT activity.
  always @(negedge clk) begin
    while (dq.size() != 0) begin
      dchk_t d;
      d = dq.pop_front();
      chk(d.nm, d.act, d.exp);
    end
    if (!rst) begin
      hs_prev = 0;
    end else begin
      while (txq.size() != 0 && txq[0].cyc < cyc) begin
        chk("tx_missing_write", 32'd0, 32'd1);
        void'(txq.pop_front());
      end
      if (nic_write) begin
        if (txq.size() == 0) begin
          chk("tx_unexpected_write", 32'd1, 32'd0);
        end else begin
          tx_exp_t e;
          e = txq.pop_front();
          chk("tx_write_cycle", 32'(cyc), 32'(e.cyc));
          chk("tx_data", 32'(nic_data_in), 32'(e.data));
          chk("tx_grant", 32'(req_ready), 32'd1 << e.idx);
          chk("tx_count_at_write", 32'(tx_count), 32'(e.cnt));
        end
      end else begin
        chk("req_ready_idle", 32'(req_ready), 32'd0);
      end
      chk("tx_busy", 32'(tx_busy), (cyc >= m_wcyc && cyc <= m_wcyc + FRAME) ? 32'd1 : 32'd0);
      if (hs_prev) chk("rx_valid_clear", 32'(rx_valid), 32'd0);
      if (nic_read) begin
        chk("read_while_valid", 32'(rx_valid), 32'd0);
        chk("read_with_nic_empty", (nic_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      end
      hs_prev = rx_valid && rx_ready;
      if (rx_valid && rx_ready) begin
        if (rxq.size() == 0) chk("rx_unexpected_byte", 32'd1, 32'd0);
        else                 chk("rx_data", 32'(rx_data), 32'(rxq.pop_front()));
      end
    end
  end

  // One cycle of stimulus plus reference-model prediction.
  task automatic body();
    logic [7:0] b;
    if (nic_read) pop_at = cyc + 2;
    if (pop_at == cyc && nic_q.size() != 0) void'(nic_q.pop_front());
    if (rx_en && nic_q.size() < 3 && $urandom_range(0, 99) < 6) begin
      b = 8'($urandom);
      nic_q.push_back(b);
      rxq.push_back(b);
      rx_total++;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (lock[i] && drop_cyc[i] == cyc) begin
        lock[i] = 0;
        if (!hold) rv[i] = 1'b0;
      end
      if (tx_en && !rv[i] && !lock[i] && tx_mask[i] && $urandom_range(0, 99) < tx_pct) begin
        rv[i] = 1'b1;
        rd[i] = 8'($urandom);
      end else if (drop_en && rv[i] && !lock[i] && $urandom_range(0, 99) < 2) begin
        rv[i] = 1'b0;
      end
    end
    req_valid = rv;
    for (int i = 0; i < N_REQ; i++) req_data[8*i +: 8] = rd[i];
    nic_rx_irq   = (nic_q.size() != 0);
    nic_data_out = (nic_q.size() != 0) ? nic_q[0] : 8'h00;
    rx_ready     = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    if (cyc >= m_next && rv != '0) begin
      int w = -1;
      tx_exp_t e;
      for (int k = 0; k < N_REQ; k++) begin
        int j = (m_ptr + k) % N_REQ;
        if (w < 0 && rv[j]) w = j;
      end
      e.cyc = cyc + 1; e.idx = w; e.data = rd[w]; e.cnt = CNT_W'(m_cnt);
      txq.push_back(e);
      m_cnt++;
      m_ptr = (w + 1) % N_REQ;
      m_next = cyc + FRAME + 2;
      m_wcyc = cyc + 1;
      lock[w] = 1;
      drop_cyc[w] = cyc + 2;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    body();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic check_all_zero(string tag);
    dchk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    dchk({tag, "_nic_data_in"}, 32'(nic_data_in), 32'd0);
    dchk({tag, "_nic_write"}, 32'(nic_write), 32'd0);
    dchk({tag, "_nic_read"}, 32'(nic_read), 32'd0);
    dchk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    dchk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    dchk({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
    dchk({tag, "_tx_count"}, 32'(tx_count), 32'd0);
    dchk({tag, "_rx_count"}, 32'(rx_count), 32'd0);
  endtask

  // Assert reset mid-cycle, check outputs drop at once, clear the model.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_all_zero("rst");
    txq.delete(); rxq.delete(); nic_q.delete();
    m_ptr = 0; m_next = 0; m_wcyc = -100; m_cnt = 0;
    rx_total = 0; pop_at = -1;
    rv = '0; hold = 0; tx_en = 0; drop_en = 0; rx_en = 0; rdy_mode = 0;
    for (int i = 0; i < N_REQ; i++) begin lock[i] = 0; drop_cyc[i] = -1; end
    repeat (2) @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    cyc = 0;
    rst = 1'b1;
    body();
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin rd[i] = 8'h00; lock[i] = 0; drop_cyc[i] = -1; end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");

    // Single requester, byte 0xA5
    rv = 2'b01; rd[0] = 8'hA5;
    release_rst();
    run(14);
    dchk("single_tx_count", 32'(tx_count), 32'd1);

    // Both requesters held continuously
    do_reset();
    hold = 1; rv = 2'b11; rd[0] = 8'h11; rd[1] = 8'h22;
    release_rst();
    run(39);
    dchk("cont_tx_count", 32'(tx_count), 32'd4);

    // Reset during GAP; pointer must restart at requester 0
    do_reset();
    hold = 1; rv = 2'b11; rd[0] = 8'h33; rd[1] = 8'h44;
    release_rst();
    run(5);
    do_reset();
    hold = 1; rv = 2'b11; rd[0] = 8'h55; rd[1] = 8'h66;
    release_rst();
    run(3);
    dchk("post_rst_tx_count", 32'(tx_count), 32'd1);

    // RX with backpressure, two bytes waiting at the NIC
    do_reset();
    nic_q.push_back(8'h3C); rxq.push_back(8'h3C);
    nic_q.push_back(8'h5A); rxq.push_back(8'h5A);
    rx_total = 2;
    release_rst();
    run(10);
    dchk("rx_bp_valid", 32'(rx_valid), 32'd1);
    dchk("rx_bp_data", 32'(rx_data), 32'h3C);
    dchk("rx_bp_count", 32'(rx_count), 32'd1);
    rdy_mode = 1;
    run(10);
    dchk("rx_two_count", 32'(rx_count), 32'd2);
    dchk("rx_two_valid", 32'(rx_valid), 32'd0);

    // 16 back-to-back writes from one requester wrap tx_count
    do_reset();
    tx_en = 1; tx_mask = 2'b01; tx_pct = 100;
    release_rst();
    run(155);
    dchk("wrap_tx_count", 32'(tx_count), 32'd0);

    // Randomised mixed traffic, then drain
    do_reset();
    tx_en = 1; tx_mask = 2'b11; tx_pct = 15; drop_en = 1; rx_en = 1; rdy_mode = 2;
    release_rst();
    run(3000);
    tx_en = 0; rx_en = 0; rdy_mode = 1;
    run(60);
    dchk("drain_txq_empty", 32'(txq.size()), 32'd0);
    dchk("drain_rxq_empty", 32'(rxq.size()), 32'd0);
    dchk("final_tx_count", 32'(tx_count), 32'(m_cnt % (1 << CNT_W)));
    dchk("final_rx_count", 32'(rx_count), 32'(rx_total % (1 << CNT_W)));

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
